sisc_fetch_unit: RTL and testbench
==================================

// Module: sisc_fetch_unit
// PURPOSE
//  Program counter, instruction register and instruction-memory fetch sequencer for the SISC.
//  Sits directly downstream of the control FSM: consumes pc_rst/pc_write/pc_sel/br_sel/ir_load.
//  Supplies opcode/mm back to the FSM, plus a branch-condition flag from mm and stat.
//  Runs the variable-latency req/valid handshake with instruction memory.
// PARAMETERS
//  PC_W      16        program counter / address width
//  IR_W      32        instruction width; opcode=ir[31:28], mm=ir[27:24], imm=ir[15:0]
//  MAX_WAIT  15        cycles in WAIT before a fetch is abandoned (1..255)
//  RESET_PC  16'h0000  PC value after rst_f or pc_rst
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst_f       in   1     reset, asynchronous, active-low
//  pc_rst      in   1     sync PC reset / fetch abort (from ctrl)
//  pc_write    in   1     load PC from pc_sel mux this cycle
//  pc_sel      in   1     0: PC+1, 1: branch target
//  br_sel      in   1     0: target = PC + sext(imm) (relative), 1: target = imm (absolute)
//  ir_load     in   1     start fetch at current PC (1-cycle pulse)
//  stat        in   4     status-register condition codes
//  imem_req    out  1     memory request, held until accepted
//  imem_addr   out  PC_W  fetch address, stable while imem_req=1
//  imem_valid  in   1     read data valid (accepts request; 1-cycle pulse)
//  imem_rdata  in   IR_W  instruction word
//  pc          out  PC_W  current PC
//  ir          out  IR_W  instruction register
//  opcode      out  4     ir[31:28]
//  mm          out  4     ir[27:24]
//  br_cond     out  1     |(mm & stat); combinational on ir and stat
//  fetch_busy  out  1     1 in REQ/WAIT/DROP
//  fetch_done  out  1     1-cycle pulse when ir is written
//  fetch_err   out  1     sticky; set on timeout, cleared by rst_f or pc_rst
// BEHAVIOUR
//  Reset (rst_f=0, async): pc=RESET_PC, ir=0, state=IDLE, all single-bit outputs 0.
//  FSM states IDLE, REQ, WAIT, DROP:
//   IDLE: ir_load=1 -> REQ; no other transitions.
//   REQ : imem_req=1, imem_addr=pc latched at ir_load; next cycle -> WAIT (imem_req held).
//   WAIT: imem_req=1; imem_valid=1 -> ir<=imem_rdata, pc<=pc+1, fetch_done=1, -> IDLE.
//         Wait counter reaching MAX_WAIT without valid -> ir<=0 (NOP), fetch_err<=1, imem_req=0, -> DROP.
//   DROP: imem_req=0; discard data on the next imem_valid, then -> IDLE.
//         A fetch that never answers leaves DROP after MAX_WAIT further cycles.
//  imem_valid in REQ counts as a WAIT capture (min latency 1 cycle after ir_load).
//  imem_valid in IDLE is ignored.
//  ir_load while fetch_busy=1: ignored; no second request, no error.
//  pc_write=1 (any state): pc <= pc_sel ? target : pc+1.
//  pc_write coincident with capture: pc_write value wins over the fetch increment; ir still captured.
//  pc_rst=1: priority over all. pc=RESET_PC, fetch_err=0.
//   From REQ/WAIT, pc_rst drops imem_req and enters DROP; the late response must not reach ir.
//  Arithmetic: all PC math is modulo 2^PC_W. 16'hFFFF+1 -> 16'h0000.
//   Relative target uses PC already advanced past the branch instruction.
//  br_cond: mm=0 gives 0 (never taken); the ctrl FSM gates pc_write with br_cond.
//  Latency: ir_load to fetch_done = memory latency + 1 cycle; fetch_done is 1 cycle.
// TESTING
//  1. rst_f pulse mid-WAIT -> pc=0, ir=0, imem_req=0 immediately. Next ir_load fetches addr 0.
//  2. pc=5, ir_load, valid 3 cycles later with 32'h1123_0001 -> ir=32'h11230001, opcode=1, pc=6, one fetch_done.
//  3. pc=16'h0010, ir imm=16'hFFFC, pc_write, pc_sel=1, br_sel=0 -> pc=16'h000C. Same with br_sel=1 -> pc=16'hFFFC.
//  4. pc=16'hFFFF, fetch completes -> pc=16'h0000. Same-cycle capture and pc_write/pc_sel=1 -> pc=target.
//  5. No valid for 15 cycles -> ir=0, fetch_err=1, imem_req=0. Late valid discarded; ir stays 0.
//  6. pc_rst during WAIT, then valid -> pc=0, ir unchanged, no fetch_done. mm=4'b0101, stat=4'b0100 -> br_cond=1; stat=4'b1010 -> 0.

Source files
------------

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: program counter, instruction register and the
// req/valid fetch sequencer that talks to instruction memory.
module sisc_fetch_unit #(
    parameter int unsigned      PC_W     = 16,
    parameter int unsigned      IR_W     = 32,
    parameter int unsigned      MAX_WAIT = 15,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic            ir_load,
    input  logic [3:0]      stat,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [IR_W-1:0] imem_rdata,
    output logic [PC_W-1:0] pc,
    output logic [IR_W-1:0] ir,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic            br_cond,
    output logic            fetch_busy,
    output logic            fetch_done,
    output logic            fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            err_q, err_d;
    logic            done_q;
    logic            launch, capture, timeout;
    logic [15:0]     imm;
    logic [PC_W-1:0] target;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q counts cycles spent in WAIT, and separately in DROP, so both give up after MAX_WAIT cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ir_load && !pc_rst) begin
                    state_d = S_REQ;
                    launch  = 1'b1;
                end
            end
            S_REQ, S_WAIT: begin
                if (pc_rst) begin
                    state_d = imem_valid ? S_IDLE : S_DROP;
                    cnt_d   = '0;
                end else if (imem_valid) begin
                    state_d = S_IDLE;
                    capture = 1'b1;
                end else if (state_q == S_REQ) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_DROP;
                    timeout = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DROP: begin
                if (imem_valid || cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = (state_q == S_REQ) || (state_q == S_WAIT);
        fetch_busy = (state_q != S_IDLE);
    end

    assign imm    = ir_q[15:0];
    assign target = br_sel ? PC_W'(imm) : pc_q + PC_W'($signed(imm));

    // An explicit PC write overrides the post-fetch increment; pc_rst overrides both
    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        addr_d = addr_q;
        err_d  = err_q;
        if (launch) begin
            addr_d = pc_q;
        end
        if (capture) begin
            ir_d = imem_rdata;
            pc_d = pc_q + PC_W'(1);
        end
        if (timeout) begin
            ir_d  = '0;
            err_d = 1'b1;
        end
        if (pc_rst) begin
            pc_d  = RESET_PC;
            err_d = 1'b0;
        end else if (pc_write) begin
            pc_d = pc_sel ? target : pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_q   <= RESET_PC;
            ir_q   <= '0;
            addr_q <= RESET_PC;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            addr_q <= addr_d;
            err_q  <= err_d;
            done_q <= capture;
        end
    end

    assign pc         = pc_q;
    assign ir         = ir_q;
    assign imem_addr  = addr_q;
    assign opcode     = ir_q[IR_W-1 -: 4];
    assign mm         = ir_q[IR_W-5 -: 4];
    assign br_cond    = |(mm & stat);
    assign fetch_done = done_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit: directed corner cases, a br_cond
// vector table and a randomized run against a transaction-level model.
module tb_sisc_fetch_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rstF;
    logic        pcRst, pcWrite, pcSel, brSel, irLoad;
    logic [3:0]  stat;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemRdata;
    logic [15:0] pc;
    logic [31:0] ir;
    logic [3:0]  opcode, mm;
    logic        brCond, fetchBusy, fetchDone, fetchErr;

    int checks   = 0;
    int failures = 0;

    sisc_fetch_unit dut (
        .clk        (clk),
        .rst_f      (rstF),
        .pc_rst     (pcRst),
        .pc_write   (pcWrite),
        .pc_sel     (pcSel),
        .br_sel     (brSel),
        .ir_load    (irLoad),
        .stat       (stat),
        .imem_req   (imemReq),
        .imem_addr  (imemAddr),
        .imem_valid (imemValid),
        .imem_rdata (imemRdata),
        .pc         (pc),
        .ir         (ir),
        .opcode     (opcode),
        .mm         (mm),
        .br_cond    (brCond),
        .fetch_busy (fetchBusy),
        .fetch_done (fetchDone),
        .fetch_err  (fetchErr)
    );

    always #5 clk = ~clk;

    // Model: a request is outstanding (mOut) or being drained (mDrop), with ages in cycles
    logic [15:0] mPc, mAddr;
    logic [31:0] mIr;
    bit          mErr, mDone, mOut, mDrop;
    int          mAge, mDropAge;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  stat;
        logic        expBr;
        logic [3:0]  expOpcode;
        logic [3:0]  expMm;
    } vec_t;

    vec_t vecs[6];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = 16'h0000; mIr = '0; mAddr = 16'h0000;
        mErr = 0; mDone = 0; mOut = 0; mDrop = 0; mAge = 0; mDropAge = 0;
    endtask

    // One clock of the model, driven by the inputs present before the edge
    task automatic modelStep();
        logic [15:0] nPc, tgt;
        logic [31:0] nIr;
        bit          nErr, nDone;
        nPc = mPc; nIr = mIr; nErr = mErr; nDone = 0;
        tgt = brSel ? mIr[15:0] : mPc + mIr[15:0];
        if (mOut) begin
            if (pcRst) begin
                mOut = 0; mDrop = !imemValid; mDropAge = 0;
            end else if (imemValid) begin
                nIr = imemRdata; nPc = mPc + 16'd1; nDone = 1; mOut = 0;
            end else if (mAge == MAX_WAIT + 1) begin
                nIr = '0; nErr = 1; mOut = 0; mDrop = 1; mDropAge = 0;
            end else begin
                mAge++;
            end
        end else if (mDrop) begin
            mDropAge++;
            if (imemValid || mDropAge == MAX_WAIT) mDrop = 0;
        end else if (irLoad && !pcRst) begin
            mOut = 1; mAge = 1; mAddr = mPc;
        end
        if (pcRst) begin
            nPc = 16'h0000; nErr = 0;
        end else if (pcWrite) begin
            nPc = pcSel ? tgt : mPc + 16'd1;
        end
        mPc = nPc; mIr = nIr; mErr = nErr; mDone = nDone;
    endtask

    task automatic checkOutput();
        checkVal("pc", pc, mPc);
        checkVal("ir", ir, mIr);
        checkVal("imem_req", imemReq, mOut);
        checkVal("fetch_busy", fetchBusy, mOut || mDrop);
        checkVal("fetch_done", fetchDone, mDone);
        checkVal("fetch_err", fetchErr, mErr);
        checkVal("opcode", opcode, mIr[31:28]);
        checkVal("mm", mm, mIr[27:24]);
        checkVal("br_cond", brCond, |(mIr[27:24] & stat));
        if (mOut) checkVal("imem_addr", imemAddr, mAddr);
    endtask

    task automatic applyStimulus(input logic irl, input logic pw, input logic ps, input logic bs,
                                 input logic prst, input logic v, input logic [31:0] rd);
        irLoad = irl; pcWrite = pw; pcSel = ps; brSel = bs;
        pcRst = prst; imemValid = v; imemRdata = rd;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic bumpPc(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic quickFetch(input logic [31:0] word);
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, word);
    endtask

    initial begin
        vecs[0] = '{32'h1523_0000, 4'b0100, 1'b1, 4'h1, 4'h5};
        vecs[1] = '{32'h1523_0000, 4'b1010, 1'b0, 4'h1, 4'h5};
        vecs[2] = '{32'h0000_0000, 4'b1111, 1'b0, 4'h0, 4'h0};
        vecs[3] = '{32'hF800_0000, 4'b1000, 1'b1, 4'hF, 4'h8};
        vecs[4] = '{32'h3F00_0000, 4'b0000, 1'b0, 4'h3, 4'hF};
        vecs[5] = '{32'h9300_0000, 4'b0010, 1'b1, 4'h9, 4'h3};

        rstF = 1'b0; pcRst = 0; pcWrite = 0; pcSel = 0; brSel = 0; irLoad = 0;
        stat = 4'h0; imemValid = 0; imemRdata = '0;
        modelReset();
        #12;
        checkVal("reset_pc", pc, 16'h0000);
        checkVal("reset_ir", ir, 32'h0);
        checkVal("reset_req", imemReq, 1'b0);
        checkVal("reset_busy", fetchBusy, 1'b0);
        checkVal("reset_done", fetchDone, 1'b0);
        checkVal("reset_err", fetchErr, 1'b0);
        rstF = 1'b1;

        // Fetch from pc=5 with a 3-cycle memory latency
        bumpPc(5);
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        idle(2);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h1123_0001);
        checkVal("t2_ir", ir, 32'h1123_0001);
        checkVal("t2_opcode", opcode, 4'h1);
        checkVal("t2_pc", pc, 16'h0006);
        checkVal("t2_done", fetchDone, 1'b1);
        idle(1);
        checkVal("t2_done_pulse", fetchDone, 1'b0);

        // Relative and absolute branch targets
        quickFetch(32'h0000_FFFC);
        bumpPc(9);
        checkVal("t3_pc_start", pc, 16'h0010);
        applyStimulus(0, 1, 1, 0, 0, 0, 32'h0);
        checkVal("t3_rel", pc, 16'h000C);
        bumpPc(4);
        applyStimulus(0, 1, 1, 1, 0, 0, 32'h0);
        checkVal("t3_abs", pc, 16'hFFFC);

        // PC wrap on fetch, then branch coincident with capture
        bumpPc(3);
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        checkVal("t4_addr", imemAddr, 16'hFFFF);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0020);
        checkVal("t4_wrap", pc, 16'h0000);
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 1, 1, 1, 0, 1, 32'h0000_1234);
        checkVal("t4_pcw_wins", pc, 16'h0020);
        checkVal("t4_ir_captured", ir, 32'h0000_1234);

        // Asynchronous reset in the middle of WAIT
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        idle(1);
        #2 rstF = 1'b0;
        #1;
        checkVal("t1_pc", pc, 16'h0000);
        checkVal("t1_ir", ir, 32'h0);
        checkVal("t1_req", imemReq, 1'b0);
        modelReset();
        #2 rstF = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        checkVal("t1_addr", imemAddr, 16'h0000);
        checkVal("t1_req_again", imemReq, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h2000_0000);

        // Timeout after MAX_WAIT cycles in WAIT, then a late response
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        idle(MAX_WAIT);
        checkVal("t5_still_waiting", imemReq, 1'b1);
        checkVal("t5_no_err_yet", fetchErr, 1'b0);
        idle(1);
        checkVal("t5_ir_nop", ir, 32'h0);
        checkVal("t5_err", fetchErr, 1'b1);
        checkVal("t5_req_off", imemReq, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        checkVal("t5_late_ir", ir, 32'h0);
        checkVal("t5_late_done", fetchDone, 1'b0);
        checkVal("t5_idle", fetchBusy, 1'b0);

        // pc_rst during WAIT aborts the fetch and clears the error
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
        checkVal("t6_pc", pc, 16'h0000);
        checkVal("t6_err_clr", fetchErr, 1'b0);
        checkVal("t6_req_off", imemReq, 1'b0);
        checkVal("t6_drop", fetchBusy, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hAAAA_5555);
        checkVal("t6_ir_kept", ir, 32'h0);
        checkVal("t6_no_done", fetchDone, 1'b0);

        // Branch-condition vector table
        for (int i = 0; i < 6; i++) begin
            quickFetch(vecs[i].word);
            stat = vecs[i].stat;
            #1;
            checkVal($sformatf("vec%0d_br_cond", i), brCond, vecs[i].expBr);
            checkVal($sformatf("vec%0d_opcode", i), opcode, vecs[i].expOpcode);
            checkVal($sformatf("vec%0d_mm", i), mm, vecs[i].expMm);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            stat = 4'($urandom);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                          1'($urandom), 1'($urandom), $urandom_range(0, 39) == 0,
                          $urandom_range(0, 4) == 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
